// File: rtl/eva_score_engine.sv
// EVA score engine: snapshots per-age hit/eviction counters and computes
// fixed-point suffix hit-probability scores, published as double-buffered tables.
module eva_score_engine #(
    parameter int k      = 3,
    parameter int ctrLen = 10,
    parameter int F      = 10,
    parameter int sumW   = 13
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         update_EVA,
    input  logic [ctrLen*(2**k)-1:0]     hitCtr_R_1D,
    input  logic [ctrLen*(2**k)-1:0]     evictionCtr_R_1D,
    input  logic [ctrLen*(2**k)-1:0]     hitCtr_NR_1D,
    input  logic [ctrLen*(2**k)-1:0]     evictionCtr_NR_1D,
    output logic [(F+1)*(2**k)-1:0]      eva_R_1D,
    output logic [(F+1)*(2**k)-1:0]      eva_NR_1D,
    output logic                         scores_valid,
    output logic                         busy
);
    localparam int N  = 2**k;
    localparam int S  = F + 1;
    localparam int CW = $clog2(F + 1);

    typedef enum logic [2:0] {IDLE, CAPTURE, ACCUM, DIV, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic              pending;
    logic              cls;
    logic [k-1:0]      age;
    logic [sumW-1:0]   h_sum, e_sum;
    logic [sumW-1:0]   hit_ext, ev_ext;
    logic [sumW:0]     rem, trial;
    logic              ge;
    logic [F:0]        q;
    logic [CW-1:0]     div_cnt;

    logic [ctrLen-1:0] hit_snap [2][N];
    logic [ctrLen-1:0] ev_snap  [2][N];
    logic [S-1:0]      work     [2][N];
    logic [S-1:0]      comm     [2][N];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (update_EVA || pending) state_nxt = CAPTURE;
            CAPTURE: state_nxt = ACCUM;
            ACCUM:   state_nxt = DIV;
            DIV:     if (div_cnt == CW'(F)) state_nxt = WRITE;
            WRITE:   state_nxt = (age == '0 && cls) ? DONE : ACCUM;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hit_ext = sumW'(hit_snap[cls][age]);
        ev_ext  = sumW'(ev_snap[cls][age]);
        // First divide cycle starts from H itself; later cycles shift the remainder.
        trial   = (div_cnt == '0) ? {1'b0, h_sum} : {rem[sumW-1:0], 1'b0};
        ge      = (trial >= {1'b0, e_sum});
    end

    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            for (int unsigned a = 0; a < N; a++) begin
                hit_snap[0][a] <= hitCtr_R_1D[a*ctrLen +: ctrLen];
                ev_snap[0][a]  <= evictionCtr_R_1D[a*ctrLen +: ctrLen];
                hit_snap[1][a] <= hitCtr_NR_1D[a*ctrLen +: ctrLen];
                ev_snap[1][a]  <= evictionCtr_NR_1D[a*ctrLen +: ctrLen];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 1'b0;
            cls     <= 1'b0;
            age     <= '0;
            h_sum   <= '0;
            e_sum   <= '0;
            rem     <= '0;
            q       <= '0;
            div_cnt <= '0;
            for (int unsigned a = 0; a < N; a++) begin
                work[0][a] <= '0;
                work[1][a] <= '0;
                comm[0][a] <= '0;
                comm[1][a] <= '0;
            end
        end else begin
            if (update_EVA && state != IDLE)
                pending <= 1'b1;
            else if (state == IDLE && (update_EVA || pending))
                pending <= 1'b0;

            case (state)
                CAPTURE: begin
                    cls   <= 1'b0;
                    age   <= '1;
                    h_sum <= '0;
                    e_sum <= '0;
                end
                ACCUM: begin
                    h_sum   <= h_sum + hit_ext;
                    e_sum   <= e_sum + hit_ext + ev_ext;
                    div_cnt <= '0;
                end
                DIV: begin
                    rem     <= ge ? (trial - {1'b0, e_sum}) : trial;
                    q       <= {q[F-1:0], ge};
                    div_cnt <= div_cnt + 1'b1;
                end
                WRITE: begin
                    work[cls][age] <= (e_sum == '0) ? '0 : q;
                    if (age != '0) begin
                        age <= age - 1'b1;
                    end else if (!cls) begin
                        cls   <= 1'b1;
                        age   <= '1;
                        h_sum <= '0;
                        e_sum <= '0;
                    end
                end
                DONE: comm <= work;
                default: ;
            endcase
        end
    end

    // During DONE the fresh working tables drive the outputs so they appear with the pulse.
    always_comb begin
        eva_R_1D  = '0;
        eva_NR_1D = '0;
        for (int unsigned a = 0; a < N; a++) begin
            eva_R_1D[a*S +: S]  = (state == DONE) ? work[0][a] : comm[0][a];
            eva_NR_1D[a*S +: S] = (state == DONE) ? work[1][a] : comm[1][a];
        end
        scores_valid = (state == DONE);
        busy         = (state != IDLE);
    end
endmodule

// File: tb/tb_eva_score_engine.sv
// Directed bench for eva_score_engine: table of counter sets with hand-computed
// score tables, plus cycle-accurate pending-request and mid-run reset sequences.
module tb_eva_score_engine;
    localparam int N  = 8;
    localparam int CL = 10;
    localparam int S  = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             update_EVA = 1'b0;
    logic [CL*N-1:0]  hitCtr_R_1D = '0;
    logic [CL*N-1:0]  evictionCtr_R_1D = '0;
    logic [CL*N-1:0]  hitCtr_NR_1D = '0;
    logic [CL*N-1:0]  evictionCtr_NR_1D = '0;
    logic [S*N-1:0]   eva_R_1D, eva_NR_1D;
    logic             scores_valid, busy;

    typedef struct packed {
        logic [CL*N-1:0] hr, er, hn, en;
        logic [S*N-1:0]  xr, xn;
    } vec_t;

    vec_t vecs [6];
    int   n_vec = 0;
    int   n_bad = 0;
    int   lat;

    eva_score_engine #(.k(3), .ctrLen(10), .F(10), .sumW(13)) dut (
        .clk               (clk),
        .rst               (rst),
        .update_EVA        (update_EVA),
        .hitCtr_R_1D       (hitCtr_R_1D),
        .evictionCtr_R_1D  (evictionCtr_R_1D),
        .hitCtr_NR_1D      (hitCtr_NR_1D),
        .evictionCtr_NR_1D (evictionCtr_NR_1D),
        .eva_R_1D          (eva_R_1D),
        .eva_NR_1D         (eva_NR_1D),
        .scores_valid      (scores_valid),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [CL*N-1:0] put_c(logic [CL*N-1:0] v, int a, logic [CL-1:0] x);
        logic [CL*N-1:0] r;
        r = v;
        r[a*CL +: CL] = x;
        return r;
    endfunction

    function automatic logic [S*N-1:0] fill_s(int lo, int hi, logic [S-1:0] x);
        logic [S*N-1:0] r;
        r = '0;
        for (int a = lo; a <= hi; a++) r[a*S +: S] = x;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_tables(input string tag, input logic [S*N-1:0] xr, input logic [S*N-1:0] xn);
        for (int a = 0; a < N; a++) begin
            chk($sformatf("%s R[%0d]", tag, a), 32'(eva_R_1D[a*S +: S]), 32'(xr[a*S +: S]));
            chk($sformatf("%s NR[%0d]", tag, a), 32'(eva_NR_1D[a*S +: S]), 32'(xn[a*S +: S]));
        end
    endtask

    task automatic set_inputs(input vec_t v);
        hitCtr_R_1D       = v.hr;
        evictionCtr_R_1D  = v.er;
        hitCtr_NR_1D      = v.hn;
        evictionCtr_NR_1D = v.en;
    endtask

    // Called at a falling edge; returns cycles from request to scores_valid (400 = timeout).
    task automatic run_and_wait(output int cycles);
        update_EVA = 1'b1;
        @(negedge clk);
        update_EVA = 1'b0;
        cycles = 1;
        while (!scores_valid && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) vecs[i] = '0;
        vecs[1].hr = put_c('0, 7, 10);
        vecs[1].er = put_c('0, 7, 10);
        vecs[1].xr = fill_s(0, 7, 512);
        vecs[2].hr = put_c('0, 0, 3);
        vecs[2].er = put_c('0, 0, 1);
        vecs[2].xr = fill_s(0, 0, 768);
        vecs[3].hr = '1;
        vecs[3].hn = '1;
        vecs[3].xr = fill_s(0, 7, 1024);
        vecs[3].xn = fill_s(0, 7, 1024);
        vecs[4].hn = put_c('0, 4, 1);
        vecs[4].en = put_c('0, 4, 2);
        vecs[4].xn = fill_s(0, 4, 341);
        vecs[5].hr = put_c('0, 3, 1);
        vecs[5].er = put_c('0, 1, 1);
        vecs[5].xr = fill_s(2, 3, 1024) | fill_s(0, 1, 512);
        vecs[5].hn = put_c('0, 6, 2);
        vecs[5].en = put_c('0, 6, 5);
        vecs[5].xn = fill_s(0, 6, 292);

        repeat (3) @(negedge clk);
        chk("reset scores_valid", 32'(scores_valid), 0);
        chk("reset busy", 32'(busy), 0);
        chk_tables("reset", '0, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            set_inputs(vecs[i]);
            run_and_wait(lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 210);
            chk_tables($sformatf("vec%0d", i), vecs[i].xr, vecs[i].xn);
            @(negedge clk);
            chk($sformatf("vec%0d pulse width", i), 32'(scores_valid), 0);
            chk($sformatf("vec%0d busy after", i), 32'(busy), 0);
            @(negedge clk);
        end

        // Second request mid-run with new counters: queued, runs after one idle cycle.
        set_inputs(vecs[1]);
        update_EVA = 1'b1;
        for (int j = 1; j <= 425; j++) begin
            @(negedge clk);
            chk($sformatf("pend busy t+%0d", j), 32'(busy), 32'((j != 211) && (j <= 421)));
            chk($sformatf("pend valid t+%0d", j), 32'(scores_valid), 32'((j == 210) || (j == 421)));
            if (j == 210 || j == 300) chk_tables($sformatf("pend t+%0d", j), vecs[1].xr, vecs[1].xn);
            if (j == 421 || j == 425) chk_tables($sformatf("pend t+%0d", j), vecs[2].xr, vecs[2].xn);
            update_EVA = (j == 50);
            if (j == 50) set_inputs(vecs[2]);
        end

        // Reset mid-run with a queued request: no pulse, cleared tables, nothing restarts.
        set_inputs(vecs[5]);
        update_EVA = 1'b1;
        for (int j = 1; j <= 215; j++) begin
            @(negedge clk);
            chk($sformatf("rst busy t+%0d", j), 32'(busy), 32'(j <= 100));
            chk($sformatf("rst valid t+%0d", j), 32'(scores_valid), 0);
            if (j == 101 || j == 215) chk_tables($sformatf("rst t+%0d", j), '0, '0);
            update_EVA = (j == 60);
            rst = (j == 100);
        end
        set_inputs(vecs[3]);
        run_and_wait(lat);
        chk("after rst latency", 32'(lat), 210);
        chk_tables("after rst", vecs[3].xr, vecs[3].xn);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
